// File: rtl/write_register_file_16_bit.sv
// 16 x 16-bit register file: write port, sequenced clear-all, flat read bus.
// Optional: REG_ZERO_HARDWIRED_EN makes register 0 a constant zero.
module write_register_file_16_bit #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   clr_req,
  output logic                   busy,
  output logic                   clr_done,
  output logic [WIDTH*DEPTH-1:0] registers_flat
);

`ifdef REG_ZERO_HARDWIRED_EN
  localparam bit HARD_ZERO = 1'b1;
`else
  localparam bit HARD_ZERO = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              wr_en;
  logic              clr_en;
  logic              clr_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (clr_req)  state_nxt = CLEAR;
      CLEAR: if (clr_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_ready = 1'b0;
    busy     = 1'b0;
    unique case (state)
      IDLE:  wr_ready = 1'b1;
      CLEAR: busy     = 1'b1;
      default: ;
    endcase
  end

  assign wr_en    = wr_valid & wr_ready;
  assign clr_en   = busy;
  assign clr_last = clr_en & (idx == LAST);

  // index wraps 15->0 exactly as the clear hands back to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      idx <= '0;
    else if (clr_en) idx <= idx + 1'b1;
    else if (clr_req) idx <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_done <= 1'b0;
    else        clr_done <= clr_last;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    logic [WIDTH-1:0] q;
    if (HARD_ZERO && i == 0) begin : g_zero
      assign q = '0;
    end else begin : g_ff
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          q <= '0;
        else if (clr_en && idx == ADDR_W'(i))
          q <= '0;
        else if (wr_en && wr_addr == ADDR_W'(i))
          q <= wr_data;
      end
    end
    assign registers_flat[WIDTH*i +: WIDTH] = q;
  end

endmodule

// File: tb/tb_write_register_file_16_bit.sv
// Bench for write_register_file_16_bit: vector table, hand sequences, random vs model.
// Honours REG_ZERO_HARDWIRED_EN when the build defines it.
module tb_write_register_file_16_bit;

`ifdef REG_ZERO_HARDWIRED_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_valid;
  logic         wr_ready;
  logic [3:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         clr_req;
  logic         busy;
  logic         clr_done;
  logic [255:0] registers_flat;

  write_register_file_16_bit dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
    .registers_flat(registers_flat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: array of values plus count of clear edges remaining
  logic [15:0] m_regs [16];
  int          m_clear_left;
  logic        m_done;

  typedef struct {
    logic        v;
    logic [3:0]  a;
    logic [15:0] d;
    logic [3:0]  slot;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < 16; i++) f[16*i +: 16] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    m_clear_left = 0;
    m_done = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    m_done = 1'b0;
    if (m_clear_left == 0) begin
      if (wr_valid && !(HZ && wr_addr == 4'd0)) m_regs[wr_addr] = wr_data;
      if (clr_req) m_clear_left = 16;
    end else begin
      m_regs[16 - m_clear_left] = 16'h0;
      m_clear_left--;
      if (m_clear_left == 0) m_done = 1'b1;
    end
    #1;
    chk("flat", registers_flat, model_flat());
    chk("ready", 256'(wr_ready), 256'(m_clear_left == 0));
    chk("busy", 256'(busy), 256'(m_clear_left != 0));
    chk("done", 256'(clr_done), 256'(m_done));
  endtask

  task automatic idle_in();
    wr_valid = 1'b0; wr_addr = 4'd0; wr_data = 16'h0; clr_req = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_flat"}, registers_flat, 256'h0);
    chk({tag, "_ready"}, 256'(wr_ready), 256'h1);
    chk({tag, "_busy"}, 256'(busy), 256'h0);
    chk({tag, "_done"}, 256'(clr_done), 256'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int busy_n;
    int done_n;
    logic [255:0] exp_flat;
    logic [255:0] flat_before;
    rst_n = 1'b1;
    idle_in();
    model_reset();
    #3;
    async_reset("rst");

    // write sweep + back-to-back same address
    for (int i = 0; i < 16; i++) begin
      tbl[i].v = 1'b1;
      tbl[i].a = 4'(i);
      tbl[i].d = 16'hA000 + 16'(i);
      tbl[i].slot = 4'(i);
      tbl[i].exp = (HZ && i == 0) ? 16'h0 : 16'hA000 + 16'(i);
    end
    tbl[16] = '{1'b1, 4'd5, 16'h1234, 4'd5, 16'h1234};
    tbl[17] = '{1'b1, 4'd5, 16'hBEEF, 4'd5, 16'hBEEF};
    exp_flat = '0;
    for (int i = 0; i < 18; i++) begin
      wr_valid = tbl[i].v; wr_addr = tbl[i].a; wr_data = tbl[i].d;
      if (i == 16) flat_before = registers_flat;
      cycle();
      chk($sformatf("vec%0d", i), 256'(registers_flat[16*tbl[i].slot +: 16]),
          256'(tbl[i].exp));
      if (i < 16) exp_flat[16*i +: 16] = tbl[i].exp;
      if (i == 15) chk("sweep_all", registers_flat, exp_flat);
    end
    flat_before[95:80] = 16'hBEEF;
    chk("b2b_others", registers_flat, flat_before);
    idle_in();

    // fill with FFFF, clear, write to reg 3 held through the clear
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_addr = 4'(i); wr_data = 16'hFFFF;
      cycle();
    end
    idle_in();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 16'h00AA;
    busy_n = 0; done_n = 0;
    for (int k = 0; k < 18; k++) begin
      if (busy) busy_n++;
      if (clr_done) done_n++;
      if (k == 16) chk("clr_zero", registers_flat, 256'h0);
      cycle();
    end
    chk("clr_busy_cycles", 256'(busy_n), 256'd16);
    chk("clr_done_pulses", 256'(done_n), 256'd1);
    chk("held_wr_reg3", 256'(registers_flat[63:48]), 256'h00AA);
    idle_in();

    // simultaneous write and clear
    wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 16'h5555; clr_req = 1'b1;
    cycle();
    idle_in();
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("sim_r7_%0d", k), 256'(registers_flat[127:112]), 256'h5555);
      cycle();
    end
    chk("sim_r7_zero", 256'(registers_flat[127:112]), 256'h0);
    for (int k = 0; k < 10; k++) cycle();

    // clr_req held high across completion
    clr_req = 1'b1;
    for (int k = 0; k < 20; k++) cycle();
    idle_in();
    for (int k = 0; k < 20; k++) cycle();

    // reset after 6 CLEAR cycles
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_addr = 4'(i); wr_data = 16'h1111 * 16'(i + 1);
      cycle();
    end
    idle_in();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int k = 0; k < 6; k++) cycle();
    async_reset("midclr");
    done_n = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (clr_done) done_n++;
    end
    chk("midclr_no_done", 256'(done_n), 256'd0);

    // write to reg 0: handshake completes either way
    wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 16'h7777;
    chk("r0_ready", 256'(wr_ready), 256'h1);
    cycle();
    chk("r0_val", 256'(registers_flat[15:0]), HZ ? 256'h0 : 256'h7777);
    idle_in();

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 4'($urandom_range(0, 15));
      wr_data  = 16'($urandom);
      clr_req  = ($urandom_range(0, 24) == 0);
      cycle();
    end
    idle_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
